// File: rtl/spi_slave_cfg.sv
// Mode-configurable SPI slave with a BC-bit word, CPOL/CPHA/bit-order latched at select, and valid/ready TX/RX.
// Optional sticky overrun/underrun flags are compiled in when SPI_SLAVE_STATUS_EN is defined.
module spi_slave_cfg #(
  parameter int            BC          = 8,
  parameter int            SYNC_STAGES = 2,
  parameter logic [BC-1:0] FILL        = {BC{1'b1}}
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef SPI_SLAVE_STATUS_EN
  input  logic          status_clr,
  output logic          overrun,
  output logic          underrun,
`endif
  input  logic          cpol,
  input  logic          cpha,
  input  logic          lsb_first,
  input  logic          ss,
  input  logic          sck,
  input  logic          mosi,
  output logic          miso,
  output logic          miso_oe,
  input  logic [BC-1:0] tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic [BC-1:0] rx_data,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic          busy
);

  localparam int CW = $clog2(BC + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   ss_prev_q, ss_prev_d;
  logic                   sck_prev_q, sck_prev_d;

  logic          cpol_q, cpol_d;
  logic          cpha_q, cpha_d;
  logic          lsb_q, lsb_d;
  logic [BC-1:0] shifter_q, shifter_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BC-1:0] hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic          miso_q, miso_d;
  logic          miso_oe_q, miso_oe_d;
  logic [BC-1:0] rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          busy_q, busy_d;

  logic          ss_s, sck_s, mosi_s;
  logic          ss_fall;
  logic          sck_edge, lead_edge, trail_edge;
  logic          sample_edge, shift_edge;
  logic          cnt_last, word_done;
  logic [BC-1:0] shift_in;
  logic [BC-1:0] load_word;

  always_comb begin
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss};
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    ss_prev_d   = ss_s;
    sck_prev_d  = sck_s;
  end

  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Edges are classified against the polarity latched at select, not the live cpol pin.
  assign ss_fall     = ss_prev_q & ~ss_s;
  assign sck_edge    = sck_s ^ sck_prev_q;
  assign lead_edge   = sck_edge & (sck_s != cpol_q);
  assign trail_edge  = sck_edge & (sck_s == cpol_q);
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;

  assign cnt_last  = (cnt_q == CW'(BC - 1));
  assign word_done = (state_q == SHIFT) & ~ss_s & sample_edge & cnt_last;
  assign shift_in  = lsb_q ? {mosi_s, shifter_q[BC-1:1]} : {shifter_q[BC-2:0], mosi_s};
  assign load_word = hold_full_q ? hold_q : FILL;

  always_comb begin
    state_d     = state_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    lsb_d       = lsb_q;
    shifter_d   = shifter_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    miso_d      = miso_q;
    miso_oe_d   = miso_oe_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    busy_d      = busy_q;

    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        miso_d    = 1'b1;
        miso_oe_d = 1'b0;
        busy_d    = 1'b0;
        cnt_d     = '0;
        if (ss_fall) begin
          cpol_d  = cpol;
          cpha_d  = cpha;
          lsb_d   = lsb_first;
          state_d = LOAD;
        end
      end

      LOAD: begin
        shifter_d = load_word;
        if (hold_full_q) begin
          hold_full_d = 1'b0;
        end
        cnt_d     = '0;
        miso_d    = lsb_q ? load_word[0] : load_word[BC-1];
        miso_oe_d = 1'b1;
        state_d   = SHIFT;
      end

      SHIFT: begin
        if (ss_s) begin
          state_d   = IDLE;
          cnt_d     = '0;
          busy_d    = 1'b0;
          miso_d    = 1'b1;
          miso_oe_d = 1'b0;
        end else if (sample_edge) begin
          shifter_d = shift_in;
          cnt_d     = cnt_q + CW'(1);
          busy_d    = 1'b1;
          if (cnt_last) begin
            rx_data_d  = shift_in;
            rx_valid_d = 1'b1;
            busy_d     = 1'b0;
            state_d    = LOAD;
          end
        end else if (shift_edge) begin
          // A shift edge before any sample would re-drive the bit LOAD already put on the pin.
          if (cnt_q != '0) begin
            miso_d = lsb_q ? shifter_q[0] : shifter_q[BC-1];
          end
          if (cnt_q != '0 || cpha_q) begin
            busy_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ss_sync_q   <= '1;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      ss_prev_q   <= 1'b1;
      sck_prev_q  <= 1'b0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      lsb_q       <= 1'b0;
      shifter_q   <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      miso_q      <= 1'b1;
      miso_oe_q   <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ss_sync_q   <= ss_sync_d;
      sck_sync_q  <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ss_prev_q   <= ss_prev_d;
      sck_prev_q  <= sck_prev_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      lsb_q       <= lsb_d;
      shifter_q   <= shifter_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign miso     = miso_q;
  assign miso_oe  = miso_oe_q;
  assign tx_ready = ~hold_full_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;

`ifdef SPI_SLAVE_STATUS_EN
  logic overrun_q, overrun_d;
  logic underrun_q, underrun_d;

  // A set event in the same cycle as status_clr must survive, so sets are applied last.
  always_comb begin
    overrun_d  = overrun_q;
    underrun_d = underrun_q;
    if (status_clr) begin
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
    end
    if (word_done && rx_valid_q) begin
      overrun_d = 1'b1;
    end
    if (state_q == LOAD && !hold_full_q) begin
      underrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  assign overrun  = overrun_q;
  assign underrun = underrun_q;
`endif

endmodule

// File: tb/tb_spi_slave_cfg.sv
// Directed scoreboard bench for spi_slave_cfg: an 8-bit and a 16-bit instance driven by a bit-banged SPI master.
`timescale 1ns/1ps
module tb_spi_slave_cfg;

  localparam int HALF = 80;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic cpol, cpha, lsbFirst, sck, mosi;
  logic ss8, ss16;

  logic        miso8, misoOe8, txValid8, txReady8, rxValid8, rxReady8, busy8;
  logic [7:0]  txData8, rxData8;
  logic        miso16, misoOe16, txValid16, txReady16, rxValid16, rxReady16, busy16;
  logic [15:0] txData16, rxData16;
`ifdef SPI_SLAVE_STATUS_EN
  logic statusClr8, overrun8, underrun8;
  logic statusClr16, overrun16, underrun16;
`endif

  spi_slave_cfg #(.BC(8)) u8 (
    .clk(clk), .rst_n(rst_n),
`ifdef SPI_SLAVE_STATUS_EN
    .status_clr(statusClr8), .overrun(overrun8), .underrun(underrun8),
`endif
    .cpol(cpol), .cpha(cpha), .lsb_first(lsbFirst), .ss(ss8), .sck(sck), .mosi(mosi),
    .miso(miso8), .miso_oe(misoOe8), .tx_data(txData8), .tx_valid(txValid8), .tx_ready(txReady8),
    .rx_data(rxData8), .rx_valid(rxValid8), .rx_ready(rxReady8), .busy(busy8)
  );

  spi_slave_cfg #(.BC(16)) u16 (
    .clk(clk), .rst_n(rst_n),
`ifdef SPI_SLAVE_STATUS_EN
    .status_clr(statusClr16), .overrun(overrun16), .underrun(underrun16),
`endif
    .cpol(cpol), .cpha(cpha), .lsb_first(lsbFirst), .ss(ss16), .sck(sck), .mosi(mosi),
    .miso(miso16), .miso_oe(misoOe16), .tx_data(txData16), .tx_valid(txValid16), .tx_ready(txReady16),
    .rx_data(rxData16), .rx_valid(rxValid16), .rx_ready(rxReady16), .busy(busy16)
  );

  int checks = 0;
  int errors = 0;
  bit wide = 1'b0;

  logic [31:0] expMiso[$];
  logic [31:0] expRx[$];
  logic [31:0] mosiQ[$];
  logic [31:0] jitQ[$];

  function automatic logic misoSel();
    return wide ? miso16 : miso8;
  endfunction

  function automatic logic txReadySel();
    return wide ? txReady16 : txReady8;
  endfunction

  function automatic logic rxValidSel();
    return wide ? rxValid16 : rxValid8;
  endfunction

  function automatic logic [31:0] rxDataSel();
    return wide ? {16'h0, rxData16} : {24'h0, rxData8};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Writes one word into the TX holding register once it is free and records it as the next expected miso word.
  task automatic txWrite(input logic [31:0] w);
    int n;
    n = 0;
    @(negedge clk);
    while (!txReadySel() && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("txReadyWait", {31'h0, txReadySel()}, 32'h1);
    if (wide) begin
      txData16 = w[15:0];
      txValid16 = 1'b1;
      expMiso.push_back(w & 32'hFFFF);
    end else begin
      txData8 = w[7:0];
      txValid8 = 1'b1;
      expMiso.push_back(w & 32'hFF);
    end
    @(negedge clk);
    txValid8 = 1'b0;
    txValid16 = 1'b0;
  endtask

  task automatic acceptRx(input string tag);
    int n;
    logic [31:0] e;
    n = 0;
    @(negedge clk);
    while (!rxValidSel() && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "RxValid"}, {31'h0, rxValidSel()}, 32'h1);
    e = expRx.pop_front();
    checkOutput({tag, "RxData"}, rxDataSel(), e);
    if (wide) rxReady16 = 1'b1; else rxReady8 = 1'b1;
    @(negedge clk);
    rxReady8 = 1'b0;
    rxReady16 = 1'b0;
    checkOutput({tag, "RxCleared"}, {31'h0, rxValidSel()}, 32'h0);
  endtask

  // One word as SPI master; also notes whether miso moved shortly after any sample edge.
  task automatic masterWord(input logic [31:0] outW, input int nbits, input int stopBits,
                            output logic [31:0] inW, output bit stable);
    inW = '0;
    stable = 1'b1;
    for (int i = 0; i < stopBits; i++) begin
      int idx;
      idx = lsbFirst ? i : nbits - 1 - i;
      if (!cpha) begin
        mosi = outW[idx];
        #HALF;
        sck = ~cpol;
        inW[idx] = misoSel();
        if (i != nbits - 1) begin
          #60;
          if (misoSel() !== inW[idx]) stable = 1'b0;
          #(HALF - 60);
        end else begin
          #HALF;
        end
        sck = cpol;
      end else begin
        sck = ~cpol;
        mosi = outW[idx];
        #HALF;
        sck = cpol;
        inW[idx] = misoSel();
        if (i != nbits - 1) begin
          #60;
          if (misoSel() !== inW[idx]) stable = 1'b0;
          #(HALF - 60);
        end else begin
          #HALF;
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit wideSel, input int mode, input bit lsb, input int nWords,
                               input int stopBits, input bit keepSel, input bit autoRx);
    int nb;
    nb = wideSel ? 16 : 8;
    wide = wideSel;
    cpol = mode[1];
    cpha = mode[0];
    lsbFirst = lsb;
    sck = mode[1];
    #HALF;
    if (wideSel) ss16 = 1'b0; else ss8 = 1'b0;
    #120;
    fork
      begin
        for (int w = 0; w < nWords; w++) begin
          logic [31:0] o, r, e;
          bit st;
          o = mosiQ.pop_front();
          if (stopBits == nb) expRx.push_back(o);
          masterWord(o, nb, stopBits, r, st);
          e = expMiso.pop_front();
          if (stopBits == nb) begin
            checkOutput($sformatf("m%0d misoWord%0d", mode, w), r, e);
            checkOutput($sformatf("m%0d misoStable%0d", mode, w), {31'h0, st}, 32'h1);
          end
        end
        if (!keepSel) begin
          #HALF;
          ss8 = 1'b1;
          ss16 = 1'b1;
          #200;
        end
      end
      begin
        if (autoRx) begin
          for (int w = 0; w < nWords; w++) acceptRx($sformatf("m%0d w%0d", mode, w));
        end
      end
      begin
        while (jitQ.size() > 0) txWrite(jitQ.pop_front());
      end
    join
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not reach the end in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    cpol = 1'b0; cpha = 1'b0; lsbFirst = 1'b0; sck = 1'b0; mosi = 1'b0;
    ss8 = 1'b1; ss16 = 1'b1;
    txValid8 = 1'b0; txData8 = '0; rxReady8 = 1'b0;
    txValid16 = 1'b0; txData16 = '0; rxReady16 = 1'b0;
`ifdef SPI_SLAVE_STATUS_EN
    statusClr8 = 1'b0; statusClr16 = 1'b0;
`endif
    #22;
    checkOutput("rstMiso", {31'h0, miso8}, 32'h1);
    checkOutput("rstMisoOe", {31'h0, misoOe8}, 32'h0);
    checkOutput("rstRxData", {24'h0, rxData8}, 32'h0);
    checkOutput("rstRxValid", {31'h0, rxValid8}, 32'h0);
    checkOutput("rstTxReady", {31'h0, txReady8}, 32'h1);
    checkOutput("rstBusy", {31'h0, busy8}, 32'h0);
    checkOutput("rstTxReady16", {31'h0, txReady16}, 32'h1);
    checkOutput("rstMisoOe16", {31'h0, misoOe16}, 32'h0);
`ifdef SPI_SLAVE_STATUS_EN
    checkOutput("rstOverrun", {31'h0, overrun8}, 32'h0);
    checkOutput("rstUnderrun", {31'h0, underrun8}, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] mode 0, 8-bit MSB-first exchange");
    wide = 1'b0;
    txWrite(32'hA5);
    checkOutput("t1TxReadyDrop", {31'h0, txReady8}, 32'h0);
    mosiQ.push_back(32'h3C);
    applyStimulus(1'b0, 0, 1'b0, 1, 8, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    checkOutput("t1RxHeld", {31'h0, rxValid8}, 32'h1);
    checkOutput("t1TxReadyAfterLoad", {31'h0, txReady8}, 32'h1);
    acceptRx("t1");

    $display("[TB] modes 1..3");
    for (int m = 1; m < 4; m++) begin
      wide = 1'b0;
      txWrite(32'h5A);
      mosiQ.push_back(32'hC3);
      applyStimulus(1'b0, m, 1'b0, 1, 8, 1'b0, 1'b1);
    end

    $display("[TB] 16-bit LSB-first three-word burst");
    wide = 1'b1;
    txWrite(32'h1234);
    jitQ.push_back(32'h5678);
    jitQ.push_back(32'h9ABC);
    mosiQ.push_back(32'hBEEF);
    mosiQ.push_back(32'h0F0F);
    mosiQ.push_back(32'hC001);
    applyStimulus(1'b1, 0, 1'b1, 3, 16, 1'b0, 1'b1);

    $display("[TB] underrun fill word");
    wide = 1'b0;
    expMiso.push_back(32'hFF);
    mosiQ.push_back(32'h81);
    applyStimulus(1'b0, 0, 1'b0, 1, 8, 1'b0, 1'b1);
`ifdef SPI_SLAVE_STATUS_EN
    checkOutput("t4Underrun", {31'h0, underrun8}, 32'h1);
    @(negedge clk);
    statusClr8 = 1'b1;
    @(negedge clk);
    statusClr8 = 1'b0;
    checkOutput("t4UnderrunClr", {31'h0, underrun8}, 32'h0);
`endif

    $display("[TB] overrun with two unaccepted words");
    expMiso.push_back(32'hFF);
    expMiso.push_back(32'hFF);
    mosiQ.push_back(32'h11);
    mosiQ.push_back(32'h22);
    applyStimulus(1'b0, 0, 1'b0, 2, 8, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("t5RxValid", {31'h0, rxValid8}, 32'h1);
`ifdef SPI_SLAVE_STATUS_EN
    checkOutput("t5Overrun", {31'h0, overrun8}, 32'h1);
`endif
    void'(expRx.pop_front());
    acceptRx("t5");

    $display("[TB] select dropped after 5 bits");
    txWrite(32'h77);
    mosiQ.push_back(32'h5A);
    applyStimulus(1'b0, 0, 1'b0, 1, 5, 1'b1, 1'b0);
    checkOutput("t6BusyMid", {31'h0, busy8}, 32'h1);
    ss8 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #HALF;
      sck = ~sck;
    end
    repeat (10) @(negedge clk);
    checkOutput("t6RxValid", {31'h0, rxValid8}, 32'h0);
    checkOutput("t6Busy", {31'h0, busy8}, 32'h0);
    checkOutput("t6Miso", {31'h0, miso8}, 32'h1);
    checkOutput("t6MisoOe", {31'h0, misoOe8}, 32'h0);
    checkOutput("t6TxReady", {31'h0, txReady8}, 32'h1);
    txWrite(32'h96);
    mosiQ.push_back(32'h69);
    applyStimulus(1'b0, 0, 1'b0, 1, 8, 1'b0, 1'b1);

    $display("[TB] reset pulsed mid-word");
    txWrite(32'h4D);
    mosiQ.push_back(32'hB2);
    applyStimulus(1'b0, 2, 1'b0, 1, 4, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("t7Miso", {31'h0, miso8}, 32'h1);
    checkOutput("t7MisoOe", {31'h0, misoOe8}, 32'h0);
    checkOutput("t7Busy", {31'h0, busy8}, 32'h0);
    checkOutput("t7TxReady", {31'h0, txReady8}, 32'h1);
    checkOutput("t7RxValid", {31'h0, rxValid8}, 32'h0);
    ss8 = 1'b1;
    #40;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("t7RxValidAfter", {31'h0, rxValid8}, 32'h0);
    txWrite(32'hE1);
    mosiQ.push_back(32'h1E);
    applyStimulus(1'b0, 1, 1'b0, 1, 8, 1'b0, 1'b1);

    checkOutput("sbDrained", expRx.size() + expMiso.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
